result_bcd_display: RTL and testbench

//  Downstream display stage for the repeated-subtraction divider.
//  - Captures quotient/remainder when the controller pulses ready; shows "Err" when it flags divide-by-zero.
//  - Converts the selected value to BCD with a sequential shift-add-3 (double dabble), one bit per cycle.
//  - Drives a 4-digit multiplexed seven-segment display with leading-zero blanking.

---
 rtl/result_bcd_display.sv | 163 ++++++++++++++++
 tb/tb_result_bcd_display.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/result_bcd_display.sv
// Display stage for the repeated-subtraction divider. Captures the divider
// result, converts the selected value to BCD one bit per cycle (double
// dabble), and scans it onto a 4-digit active-low seven-segment display.
module result_bcd_display #(
  parameter int WIDTH       = 8,
  parameter int REFRESH_DIV = 50000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ready,
  input  logic             error,
  input  logic [WIDTH-1:0] quotient,
  input  logic [WIDTH-1:0] remainder,
  input  logic             show_rem,
  output logic             busy,
  output logic             valid,
  output logic [6:0]       seg,
  output logic [3:0]       an
);

  typedef enum logic [1:0] {EMPTY, CONV, SHOW, ERR} state_t;

  localparam int BW = $clog2(WIDTH + 1);
  localparam int RW = $clog2(REFRESH_DIV);

  state_t           state;
  logic [WIDTH-1:0] q_cap, r_cap, shift;
  logic [15:0]      bcd, disp;
  logic [BW-1:0]    bitcnt;
  logic             sel;
  logic             shown;   // a number has reached the display since reset
  logic [RW-1:0]    rcnt;
  logic [1:0]       idx;

  logic [15:0]       adj;
  logic [15+WIDTH:0] sh_n;
  logic [15:0]       upper;
  logic              lead_blank;
  logic [6:0]        seg_n;
  logic [3:0]        an_n;

  function automatic logic [6:0] enc(input logic [3:0] n);
    case (n)
      4'd0:    enc = 7'b1000000;
      4'd1:    enc = 7'b1111001;
      4'd2:    enc = 7'b0100100;
      4'd3:    enc = 7'b0110000;
      4'd4:    enc = 7'b0011001;
      4'd5:    enc = 7'b0010010;
      4'd6:    enc = 7'b0000010;
      4'd7:    enc = 7'b1111000;
      4'd8:    enc = 7'b0000000;
      4'd9:    enc = 7'b0010000;
      default: enc = 7'h7F;
    endcase
  endfunction

  // One double-dabble step: add 3 to nibbles >= 5, then shift {bcd,shift} left.
  always_comb begin
    adj = bcd;
    for (int i = 0; i < 4; i++)
      if (bcd[i*4 +: 4] >= 4'd5) adj[i*4 +: 4] = bcd[i*4 +: 4] + 4'd3;
    sh_n = {adj, shift} << 1;
  end

  // Control FSM: capture, conversion sequencing, display register update.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= EMPTY;
      q_cap  <= '0;
      r_cap  <= '0;
      sel    <= 1'b0;
      shift  <= '0;
      bcd    <= '0;
      bitcnt <= '0;
      disp   <= '0;
      shown  <= 1'b0;
    end else if (ready && error) begin
      state <= ERR;
    end else if (ready) begin
      q_cap  <= quotient;
      r_cap  <= remainder;
      sel    <= show_rem;
      shift  <= show_rem ? remainder : quotient;
      bcd    <= '0;
      bitcnt <= '0;
      state  <= CONV;
    end else begin
      case (state)
        CONV: begin
          bcd    <= sh_n[15+WIDTH -: 16];
          shift  <= sh_n[WIDTH-1:0];
          bitcnt <= bitcnt + 1'b1;
          if (bitcnt == BW'(WIDTH - 1)) begin
            disp  <= sh_n[15+WIDTH -: 16];
            shown <= 1'b1;
            state <= SHOW;
          end
        end
        SHOW: begin
          // Selection changed: convert the other captured value.
          if (show_rem != sel) begin
            sel    <= show_rem;
            shift  <= show_rem ? r_cap : q_cap;
            bcd    <= '0;
            bitcnt <= '0;
            state  <= CONV;
          end
        end
        default: ;
      endcase
    end
  end

  // Free-running refresh counter and digit index.
  always_ff @(posedge clk) begin
    if (reset) begin
      rcnt <= '0;
      idx  <= '0;
    end else if (rcnt == RW'(REFRESH_DIV - 1)) begin
      rcnt <= '0;
      idx  <= idx + 2'd1;
    end else begin
      rcnt <= rcnt + 1'b1;
    end
  end

  // Segment pattern for the currently indexed digit, with leading-zero blanking.
  always_comb begin
    upper      = disp >> {idx, 2'b00};
    lead_blank = (idx != 2'd0) && (upper == 16'd0);
    seg_n      = 7'h7F;
    an_n       = 4'hF;
    if (!(state == EMPTY || (state == CONV && !shown))) begin
      an_n = ~(4'b0001 << idx);
      if (state == ERR) begin
        case (idx)
          2'd3:    seg_n = 7'b0000110;
          2'd2:    seg_n = 7'b0101111;
          2'd1:    seg_n = 7'b0101111;
          default: seg_n = 7'h7F;
        endcase
      end else if (!lead_blank) begin
        seg_n = enc(upper[3:0]);
      end
    end
  end

  // Registered display drive so seg and an switch on the same edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      seg <= 7'h7F;
      an  <= 4'hF;
    end else begin
      seg <= seg_n;
      an  <= an_n;
    end
  end

  assign busy  = (state == CONV);
  assign valid = (state == SHOW);

endmodule

// File: tb/tb_result_bcd_display.sv
// Bench for result_bcd_display: directed sequences, a vector table and
// randomized results checked against a decimal-arithmetic display model.
module tb_result_bcd_display;
  localparam int W  = 8;
  localparam int RD = 4;

  logic         clk = 1'b0;
  logic         reset, ready, error, show_rem;
  logic [W-1:0] quotient, remainder;
  logic         busy, valid;
  logic [6:0]   seg;
  logic [3:0]   an;

  int total = 0;
  int bad   = 0;

  result_bcd_display #(.WIDTH(W), .REFRESH_DIV(RD)) dut (
    .clk(clk), .reset(reset), .ready(ready), .error(error),
    .quotient(quotient), .remainder(remainder), .show_rem(show_rem),
    .busy(busy), .valid(valid), .seg(seg), .an(an)
  );

  always #5 clk = ~clk;

  typedef struct {
    int q;
    int r;
    bit sr;
    bit err;
    int expv;   // -1 means the Err pattern
  } vec_t;

  vec_t tbl[$];

  logic [6:0] enc_tab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                               7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                               7'b0000000, 7'b0010000};

  // Expected segments of digit d for value v (v = -1: Err pattern).
  function automatic logic [6:0] exp_digit(input int v, input int d);
    int p = 1;
    if (v < 0) begin
      if (d == 3) return 7'b0000110;
      if (d == 2 || d == 1) return 7'b0101111;
      return 7'h7F;
    end
    for (int i = 0; i < d; i++) p *= 10;
    if (d == 0 || v >= p) return enc_tab[(v / p) % 10];
    return 7'h7F;
  endfunction

  function automatic int digit_of(input logic [3:0] a);
    case (a)
      4'b1110: return 0;
      4'b1101: return 1;
      4'b1011: return 2;
      4'b0111: return 3;
      default: return -1;
    endcase
  endfunction

  task automatic check(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic fire(input int q, input int r, input bit sr, input bit err);
    quotient  = W'(q);
    remainder = W'(r);
    show_rem  = sr;
    ready     = 1'b1;
    error     = err;
  endtask

  // Trigger already driven; checks busy window, what is held on screen, then valid.
  // prev: -3 no display check, -2 display must stay dark, >=0 value still shown.
  task automatic run_conv(input string name, input int prev);
    int nb = 0;
    int nd = 0;
    step();
    ready = 1'b0;
    error = 1'b0;
    for (int i = 0; i < W; i++) begin
      if (!(busy && !valid)) nb++;
      if (prev == -2 && an != 4'hF) nd++;
      else if (prev >= 0 && digit_of(an) >= 0 && seg != exp_digit(prev, digit_of(an))) nd++;
      step();
    end
    check({name, "_busy"}, nb, 0);
    if (prev != -3) check({name, "_hold"}, nd, 0);
    check({name, "_valid"}, {30'd0, busy, valid}, 1);
  endtask

  // Observe a full scan and compare every lit digit against the model.
  task automatic scan_check(input string name, input int v, input bit toggle);
    int bad_d[4] = '{0, 0, 0, 0};
    int seen[4]  = '{0, 0, 0, 0};
    int badoh = 0, badper = 0, run = 0, changes = 0;
    logic [3:0] last;
    step();
    last = an;
    for (int c = 0; c < 4 * RD + 2; c++) begin
      int d;
      if (toggle) show_rem = ~show_rem;
      d = digit_of(an);
      if (d < 0) badoh++;
      else begin
        seen[d]++;
        if (seg != exp_digit(v, d)) bad_d[d]++;
      end
      if (an != last) begin
        if (changes > 0 && run != RD) badper++;
        changes++;
        run = 0;
        last = an;
      end
      run++;
      step();
    end
    check({name, "_an_onehot"}, badoh, 0);
    check({name, "_scan_period"}, badper, 0);
    for (int d = 0; d < 4; d++)
      check($sformatf("%s_d%0d", name, d), bad_d[d] + (seen[d] == 0 ? 100 : 0), 0);
  endtask

  initial begin
    int nerr;
    tbl.push_back('{q: 0,   r: 0,   sr: 0, err: 0, expv: 0});
    tbl.push_back('{q: 255, r: 7,   sr: 0, err: 0, expv: 255});
    tbl.push_back('{q: 10,  r: 100, sr: 1, err: 0, expv: 100});
    tbl.push_back('{q: 9,   r: 0,   sr: 0, err: 1, expv: -1});
    tbl.push_back('{q: 100, r: 5,   sr: 0, err: 0, expv: 100});
    tbl.push_back('{q: 8,   r: 99,  sr: 1, err: 0, expv: 99});
    tbl.push_back('{q: 1,   r: 250, sr: 1, err: 0, expv: 250});

    reset = 1'b1; ready = 1'b0; error = 1'b0; show_rem = 1'b0;
    quotient = '0; remainder = '0;

    // 1: reset state, and it persists with no ready
    repeat (3) step();
    check("rst_busy", busy, 0);
    check("rst_valid", valid, 0);
    check("rst_seg", seg, 7'h7F);
    check("rst_an", an, 4'hF);
    reset = 1'b0;
    nerr = 0;
    error = 1'b1;   // error without ready must be ignored
    for (int i = 0; i < 12; i++) begin
      if (busy || valid || seg != 7'h7F || an != 4'hF) nerr++;
      step();
    end
    error = 1'b0;
    check("idle_dark", nerr, 0);

    // 2: first conversion, display dark while converting
    fire(123, 4, 0, 0);
    run_conv("t2", -2);
    scan_check("t2", 123, 0);

    // 3: switch to remainder, 123 held during reconversion
    show_rem = 1'b1;
    run_conv("t3", 123);
    scan_check("t3", 4, 0);

    // 4: divide-by-zero, show_rem toggled during the scan
    fire(5, 5, 1, 1);
    step();
    ready = 1'b0; error = 1'b0;
    check("t4_err_valid", {30'd0, busy, valid}, 0);
    scan_check("t4", -1, 1);
    check("t4_err_still", {30'd0, busy, valid}, 0);

    // 5: restart by a second ready three cycles after the first
    fire(200, 1, 0, 0);
    step();
    ready = 1'b0;
    step();
    step();
    fire(9, 1, 0, 0);
    run_conv("t5", -3);
    scan_check("t5", 9, 0);
    fire(0, 3, 0, 0);
    run_conv("t5z", 9);
    scan_check("t5z", 0, 0);

    // Vector table
    foreach (tbl[k]) begin
      fire(tbl[k].q, tbl[k].r, tbl[k].sr, tbl[k].err);
      if (tbl[k].err) begin
        step();
        ready = 1'b0; error = 1'b0;
        check($sformatf("v%0d_err", k), {30'd0, busy, valid}, 0);
        scan_check($sformatf("v%0d", k), tbl[k].expv, 0);
      end else begin
        run_conv($sformatf("v%0d", k), -3);
        scan_check($sformatf("v%0d", k), tbl[k].expv, 0);
      end
    end

    // Randomized results against the decimal model
    for (int n = 0; n < 12; n++) begin
      int q, r, shown_v;
      bit sr, err;
      q   = $urandom_range(0, 255);
      r   = $urandom_range(0, 255);
      sr  = $urandom_range(0, 1);
      err = ($urandom_range(0, 4) == 0);
      fire(q, r, sr, err);
      if (err) begin
        step();
        ready = 1'b0; error = 1'b0;
        check($sformatf("r%0d_err", n), {30'd0, busy, valid}, 0);
        scan_check($sformatf("r%0d", n), -1, 0);
      end else begin
        shown_v = sr ? r : q;
        run_conv($sformatf("r%0d", n), -3);
        scan_check($sformatf("r%0d", n), shown_v, 0);
        if ($urandom_range(0, 1) == 1) begin
          show_rem = ~sr;
          run_conv($sformatf("r%0d_sw", n), shown_v);
          scan_check($sformatf("r%0d_sw", n), sr ? q : r, 0);
        end
      end
    end

    // 6: reset in the 4th conversion cycle
    fire(55, 66, 0, 0);
    step();
    ready = 1'b0;
    step(); step(); step();
    check("t6_mid_busy", busy, 1);
    reset = 1'b1;
    step();
    check("t6_busy", busy, 0);
    check("t6_valid", valid, 0);
    check("t6_an", an, 4'hF);
    reset = 1'b0;
    nerr = 0;
    for (int i = 0; i < 24; i++) begin
      if (busy || valid || an != 4'hF || seg != 7'h7F) nerr++;
      step();
    end
    check("t6_no_stale", nerr, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
